fc_writeback_engine: RTL

Sequencer that sits on the opposite end of the register-file interface from the FC datapath. It reads the input vector and bias registers through the register file's op_address/reg_o read port and takes the weight matrix from the flattened weight export. It computes FC_OUTPUT_SIZE signed dot products using one serial MAC, then writes the packed, saturated result and per-byte positivity tags back through the RDaddr/RDdata/RegWrite/is_pos write port.

---
 rtl/fc_writeback_engine.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/fc_writeback_engine.sv
// ============================================================================
// Module      : fc_writeback_engine
// Description : Serial-MAC fully-connected sequencer. It fetches the input and
//               bias words through the register-file read port and writes the
//               saturated, packed result back with per-byte positivity tags.
//               Optional macro FC_RELU_EN clamps negative results to zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fc_writeback_engine #(
    parameter int FC_BITWIDTH    = 8,
    parameter int FC_INPUT_SIZE  = 4,
    parameter int FC_OUTPUT_SIZE = 2,
    parameter int ACC_WIDTH      = 20
) (
    input  logic                                                 clk_i,
    input  logic                                                 reset,
    input  logic                                                 start_i,
    input  logic [4:0]                                           src_addr_i,
    input  logic [4:0]                                           bias_addr_i,
    input  logic [4:0]                                           dst_addr_i,
    output logic [4:0]                                           op_address_o,
    input  logic [31:0]                                          reg_i,
    input  logic [FC_BITWIDTH*FC_INPUT_SIZE*FC_OUTPUT_SIZE-1:0]  weight_matrix_i,
    output logic [4:0]                                           RDaddr_o,
    output logic [31:0]                                          RDdata_o,
    output logic                                                 RegWrite_o,
    output logic [3:0]                                           is_pos_o,
    output logic                                                 busy_o,
    output logic                                                 done_o
);

    localparam int c_BW   = FC_BITWIDTH;
    localparam int c_WM_W = FC_BITWIDTH * FC_INPUT_SIZE * FC_OUTPUT_SIZE;
    localparam int c_IW   = (FC_INPUT_SIZE > 1) ? $clog2(FC_INPUT_SIZE) : 1;
    localparam int c_JW   = (FC_OUTPUT_SIZE > 1) ? $clog2(FC_OUTPUT_SIZE) : 1;

    localparam logic [c_IW-1:0] c_I_LAST = c_IW'(FC_INPUT_SIZE - 1);
    localparam logic [c_JW-1:0] c_J_LAST = c_JW'(FC_OUTPUT_SIZE - 1);

    localparam logic signed [ACC_WIDTH-1:0] c_SAT_MAX = ACC_WIDTH'(2 ** (FC_BITWIDTH - 1) - 1);
    localparam logic signed [ACC_WIDTH-1:0] c_SAT_MIN = ACC_WIDTH'(-(2 ** (FC_BITWIDTH - 1)));

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_FETCH_IN   = 3'd1,
        S_FETCH_BIAS = 3'd2,
        S_MAC        = 3'd3,
        S_WRITE      = 3'd4,
        S_DONE       = 3'd5
    } state_t;

    state_t                        state_q, state_d;
    logic [4:0]                    src_q, src_d;
    logic [4:0]                    bias_addr_q, bias_addr_d;
    logic [4:0]                    dst_q, dst_d;
    logic [c_WM_W-1:0]             wt_q, wt_d;
    logic [31:0]                   vec_q, vec_d;
    logic [31:0]                   bias_q, bias_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [c_IW-1:0]               i_q, i_d;
    logic [c_JW-1:0]               j_q, j_d;
    logic [31:0]                   res_q, res_d;
    logic [3:0]                    tag_q, tag_d;

    logic signed [c_BW-1:0]        x_sel;
    logic signed [c_BW-1:0]        w_sel;
    logic signed [c_BW-1:0]        b_sel;
    logic signed [2*c_BW-1:0]      prod;
    logic signed [ACC_WIDTH-1:0]   acc_base;
    logic signed [ACC_WIDTH-1:0]   sum;
    logic [c_BW-1:0]               sat_byte;
    logic                          sum_pos;

    // Operand selection for the current (row j, element i) MAC step.
    always_comb begin
        x_sel = '0;
        w_sel = '0;
        b_sel = '0;
        for (int k = 0; k < FC_INPUT_SIZE; k++) begin
            if (int'(i_q) == k) x_sel = vec_q[k*c_BW +: c_BW];
        end
        for (int jj = 0; jj < FC_OUTPUT_SIZE; jj++) begin
            if (int'(j_q) == jj) b_sel = bias_q[31-c_BW*jj -: c_BW];
            for (int k = 0; k < FC_INPUT_SIZE; k++) begin
                if (int'(j_q) == jj && int'(i_q) == k)
                    w_sel = wt_q[((FC_OUTPUT_SIZE-1-jj)*FC_INPUT_SIZE + k)*c_BW +: c_BW];
            end
        end
        prod     = x_sel * w_sel;
        acc_base = (i_q == '0) ? {{(ACC_WIDTH-c_BW){b_sel[c_BW-1]}}, b_sel} : acc_q;
        sum      = acc_base + {{(ACC_WIDTH-2*c_BW){prod[2*c_BW-1]}}, prod};
        sum_pos  = !sum[ACC_WIDTH-1] && (sum != '0);
        if (sum > c_SAT_MAX)
            sat_byte = c_SAT_MAX[c_BW-1:0];
        else if (sum < c_SAT_MIN)
            sat_byte = c_SAT_MIN[c_BW-1:0];
        else
            sat_byte = sum[c_BW-1:0];
`ifdef FC_RELU_EN
        if (sum[ACC_WIDTH-1]) sat_byte = '0;
`endif
    end

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        bias_addr_d  = bias_addr_q;
        dst_d        = dst_q;
        wt_d         = wt_q;
        vec_d        = vec_q;
        bias_d       = bias_q;
        acc_d        = acc_q;
        i_d          = i_q;
        j_d          = j_q;
        res_d        = res_q;
        tag_d        = tag_q;
        op_address_o = '0;
        RDaddr_o     = '0;
        RDdata_o     = '0;
        RegWrite_o   = 1'b0;
        is_pos_o     = '0;
        done_o       = 1'b0;
        busy_o       = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    src_d       = src_addr_i;
                    bias_addr_d = bias_addr_i;
                    dst_d       = dst_addr_i;
                    wt_d        = weight_matrix_i;
                    i_d         = '0;
                    j_d         = '0;
                    state_d     = S_FETCH_IN;
                end
            end
            S_FETCH_IN: begin
                op_address_o = src_q;
                vec_d        = reg_i;
                state_d      = S_FETCH_BIAS;
            end
            S_FETCH_BIAS: begin
                op_address_o = bias_addr_q;
                bias_d       = reg_i;
                state_d      = S_MAC;
            end
            S_MAC: begin
                acc_d = sum;
                if (i_q == c_I_LAST) begin
                    i_d = '0;
                    for (int jj = 0; jj < FC_OUTPUT_SIZE; jj++) begin
                        if (int'(j_q) == jj) begin
                            res_d[jj*c_BW +: c_BW] = sat_byte;
                            tag_d[jj]              = sum_pos;
                        end
                    end
                    if (j_q == c_J_LAST) begin
                        j_d     = '0;
                        state_d = S_WRITE;
                    end else begin
                        j_d = j_q + c_JW'(1);
                    end
                end else begin
                    i_d = i_q + c_IW'(1);
                end
            end
            S_WRITE: begin
                RegWrite_o = 1'b1;
                RDaddr_o   = dst_q;
                RDdata_o   = res_q;
                is_pos_o   = tag_q;
                state_d    = S_DONE;
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_q     <= S_IDLE;
            src_q       <= '0;
            bias_addr_q <= '0;
            dst_q       <= '0;
            wt_q        <= '0;
            vec_q       <= '0;
            bias_q      <= '0;
            acc_q       <= '0;
            i_q         <= '0;
            j_q         <= '0;
            res_q       <= '0;
            tag_q       <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            bias_addr_q <= bias_addr_d;
            dst_q       <= dst_d;
            wt_q        <= wt_d;
            vec_q       <= vec_d;
            bias_q      <= bias_d;
            acc_q       <= acc_d;
            i_q         <= i_d;
            j_q         <= j_d;
            res_q       <= res_d;
            tag_q       <= tag_d;
        end
    end

endmodule

`default_nettype wire
